uart_frame_tx: RTL and testbench

UART transmitter for the FPGA-to-host link, the transmit-side counterpart of the 64-bit frame receiver. It accepts one BYTES-wide data frame over a valid/ready handshake and serializes it as BYTES consecutive 8N1 UART characters on uart_tx. Each character is LSB-first, and byte 0 (frame_data[7:0]) is sent first. The baud rate comes from a per-bit clock-count divider: 50 MHz / 115200 baud = 434 clocks per bit.

---
 rtl/uart_frame_tx.sv | 143 ++++++++++++++
 tb/tb_uart_frame_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serializes one BYTES-wide frame as consecutive 8N1 UART characters,
// byte 0 first, each character LSB first, CLKS_PER_BIT clocks per bit.
module uart_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned BYTES        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*BYTES-1:0]   frame_data,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned FRAME_W = 8 * BYTES;
    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BYTE_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    baud_cnt, baud_cnt_nxt;
    logic [2:0]          bit_idx, bit_idx_nxt;
    logic [BYTE_W-1:0]   byte_idx, byte_idx_nxt;
    logic [FRAME_W-1:0]  shreg, shreg_nxt;
    logic                uart_tx_nxt;
    logic                busy_nxt;
    logic                tx_done_nxt;
    logic                bit_end;

    // Ready is a direct decode of the idle state so a frame can be taken in the tx_done cycle
    assign frame_ready = (state == IDLE);
    assign bit_end     = (baud_cnt == CNT_LAST);

    // State, datapath and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            byte_idx <= byte_idx_nxt;
            shreg    <= shreg_nxt;
            uart_tx  <= uart_tx_nxt;
            busy     <= busy_nxt;
            tx_done  <= tx_done_nxt;
        end
    end

    // Next-state, counters, and the line level for the upcoming cycle
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        shreg_nxt    = shreg;
        tx_done_nxt  = 1'b0;
        uart_tx_nxt  = 1'b1;
        busy_nxt     = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                bit_idx_nxt  = '0;
                byte_idx_nxt = '0;
                if (frame_valid) begin
                    shreg_nxt = frame_data;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    state_nxt    = DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    if (byte_idx == BYTE_LAST) begin
                        byte_idx_nxt = '0;
                        tx_done_nxt  = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        byte_idx_nxt = byte_idx + BYTE_W'(1);
                        shreg_nxt    = shreg >> 8;
                        state_nxt    = START;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Line level follows the state being entered so uart_tx stays a plain register
        case (state_nxt)
            START:   uart_tx_nxt = 1'b0;
            DATA:    uart_tx_nxt = shreg_nxt[bit_idx_nxt];
            default: uart_tx_nxt = 1'b1;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: a fast instance (4 clocks/bit, 8 bytes) checked character by
// character against a byte scoreboard, plus a default-rate single-byte instance for timing.
module tb_uart_frame_tx;

    localparam int unsigned CPB      = 4;
    localparam int unsigned NB       = 8;
    localparam int unsigned CHAR_CLK = 10 * CPB;
    localparam int unsigned FRAME_CLK = NB * CHAR_CLK;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        uart_tx;
    logic        busy;
    logic        tx_done;

    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_tx;
    logic        s_busy;
    logic        s_done;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned last_start = 0;
    int unsigned last_done = 0;
    logic [7:0]  exp_q[$];

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .BYTES(NB)) u_fast (
        .clk         (clk),
        .reset       (reset),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    uart_frame_tx #(.BYTES(1)) u_slow (
        .clk         (clk),
        .reset       (reset),
        .frame_data  (s_data),
        .frame_valid (s_valid),
        .frame_ready (s_ready),
        .uart_tx     (s_tx),
        .busy        (s_busy),
        .tx_done     (s_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (tx_done) done_cnt <= done_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [63:0] d);
        logic [63:0] t;
        for (int i = 0; i < int'(NB); i++) begin
            t = d >> (8 * i);
            exp_q.push_back(t[7:0]);
        end
    endtask

    // Drive one frame from idle; data is scrambled after the accept edge
    task automatic send_frame(input logic [63:0] d);
        @(negedge clk);
        check_eq("send_ready", 64'(frame_ready), 64'd1);
        frame_data  = d;
        frame_valid = 1'b1;
        push_frame(d);
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        frame_data  = ~d;
    endtask

    // Capture one full frame off the line and compare each character to the scoreboard
    task automatic recv_frame(input int unsigned max_wait);
        logic [39:0] obs;
        logic [39:0] expv;
        logic [7:0]  b;
        logic        seen;
        logic        busy_ok;
        logic        ready_ok;
        logic        done_ok;
        int          j;
        seen = 1'b0;
        for (int unsigned w = 0; w < max_wait && !seen; w++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) seen = 1'b1;
        end
        check_eq("start_seen", 64'(seen), 64'd1);
        if (!seen) return;
        last_start = cyc;
        busy_ok  = 1'b1;
        ready_ok = 1'b1;
        done_ok  = 1'b1;
        for (int c = 0; c < int'(NB); c++) begin
            for (int k = 0; k < int'(CHAR_CLK); k++) begin
                if (!(c == 0 && k == 0)) @(negedge clk);
                obs[6'(k)] = uart_tx;
                busy_ok  = busy_ok & busy;
                ready_ok = ready_ok & ~frame_ready;
                done_ok  = done_ok & ~tx_done;
            end
            b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            for (int k = 0; k < int'(CHAR_CLK); k++) begin
                j = k / int'(CPB);
                if (j == 0)      expv[6'(k)] = 1'b0;
                else if (j == 9) expv[6'(k)] = 1'b1;
                else             expv[6'(k)] = b[3'(j - 1)];
            end
            check_eq($sformatf("char%0d", c), 64'(obs), 64'(expv));
        end
        check_eq("busy_during_frame", 64'(busy_ok), 64'd1);
        check_eq("ready_low_during_frame", 64'(ready_ok), 64'd1);
        check_eq("no_early_done", 64'(done_ok), 64'd1);
        @(negedge clk);
        last_done = cyc;
        check_eq("done_pulse", 64'(tx_done), 64'd1);
        check_eq("done_ready", 64'(frame_ready), 64'd1);
        check_eq("done_line_idle", 64'(uart_tx), 64'd1);
        check_eq("done_latency", 64'(last_done - last_start), 64'(FRAME_CLK));
    endtask

    initial begin
        int unsigned d0;
        int unsigned done1;
        int unsigned low;
        int unsigned high;
        logic        seen;

        reset       = 1'b1;
        frame_valid = 1'b0;
        frame_data  = '0;
        s_valid     = 1'b0;
        s_data      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx", 64'(uart_tx), 64'd1);
        check_eq("rst_ready", 64'(frame_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(tx_done), 64'd0);
        check_eq("rst_slow_tx", 64'(s_tx), 64'd1);
        check_eq("rst_slow_ready", 64'(s_ready), 64'd1);
        reset = 1'b0;

        // Single frame
        d0 = done_cnt;
        send_frame(64'h0123_4567_89AB_CDEF);
        recv_frame(10);
        repeat (5) @(negedge clk);
        check_eq("single_done_count", 64'(done_cnt - d0), 64'd1);

        // Boundary data
        send_frame(64'h0);
        recv_frame(10);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF);
        recv_frame(10);
        repeat (3) @(negedge clk);

        // Busy-ignore with the held frame then taken back-to-back in the tx_done cycle
        d0 = done_cnt;
        send_frame(64'h0123_4567_89AB_CDEF);
        fork
            recv_frame(10);
            begin
                repeat (50) @(negedge clk);
                check_eq("ignore_ready", 64'(frame_ready), 64'd0);
                frame_data  = 64'hAAAA_AAAA_AAAA_AAAA;
                frame_valid = 1'b1;
                push_frame(64'hAAAA_AAAA_AAAA_AAAA);
                seen = 1'b0;
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(negedge clk);
                    if (frame_ready) seen = 1'b1;
                end
                @(posedge clk);
                #1;
                frame_valid = 1'b0;
                frame_data  = 64'h1111_2222_3333_4444;
            end
        join
        done1 = last_done;
        recv_frame(10);
        check_eq("b2b_gap", 64'(last_start - done1), 64'd1);
        check_eq("b2b_done_spacing", 64'(last_done - done1), 64'(FRAME_CLK + 1));
        repeat (5) @(negedge clk);
        check_eq("b2b_done_count", 64'(done_cnt - d0), 64'd2);

        // Reset during data of byte 3
        send_frame(64'h0123_4567_89AB_CDEF);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) seen = 1'b1;
        end
        check_eq("mid_start_seen", 64'(seen), 64'd1);
        repeat (130) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_tx", 64'(uart_tx), 64'd1);
        check_eq("mid_rst_ready", 64'(frame_ready), 64'd1);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (400) @(negedge clk);
        check_eq("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("mid_rst_line_idle", 64'(uart_tx), 64'd1);
        send_frame(64'h55);
        recv_frame(10);

        // Reset wins over a simultaneous accept
        @(negedge clk);
        reset       = 1'b1;
        frame_valid = 1'b1;
        frame_data  = 64'h0;
        @(negedge clk);
        reset       = 1'b0;
        frame_valid = 1'b0;
        check_eq("rst_prio_busy", 64'(busy), 64'd0);
        check_eq("rst_prio_ready", 64'(frame_ready), 64'd1);
        repeat (8) @(negedge clk);
        check_eq("rst_prio_line", 64'(uart_tx), 64'd1);

        // Default bit rate: zero byte start+data low time and stop bit width
        @(negedge clk);
        s_data  = 8'h00;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'hFF;
        @(negedge clk);
        low = 0;
        while (s_tx == 1'b0 && low < 5000) begin
            low++;
            @(negedge clk);
        end
        high = 0;
        while (s_tx == 1'b1 && s_done == 1'b0 && high < 1000) begin
            high++;
            @(negedge clk);
        end
        check_eq("slow_low_time", 64'(low), 64'd3906);
        check_eq("slow_stop_time", 64'(high), 64'd434);
        check_eq("slow_done", 64'(s_done), 64'd1);
        check_eq("slow_ready", 64'(s_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
